fifo_wr_ctrl: RTL and testbench

//  Parametrised write-side controller for the dual-clock FIFO, in the w_clk domain.
//  - Owns the binary write pointer and the registered Gray write pointer.
//  - Generates the full, almost-full, fill-level and memory write-enable signals.
//  - Works at any depth 2^ADDR_WIDTH. Replaces the fixed 16-entry case-table controller.
//  - gray_wr_ptr feeds the rd_clk 2-flop synchronizer.
//  - sync_rd_ptr arrives from the mirror synchronizer in the w_clk domain.

---
 rtl/fifo_wr_ctrl.sv | 74 +++++++
 tb/tb_fifo_wr_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of the dual-clock FIFO: binary/Gray write pointers, full/afull/level, write strobe.
// Optional sticky overflow flag enabled by defining FIFO_WR_OVF_EN.
module fifo_wr_ctrl #(
  parameter int unsigned ADDR_WIDTH   = 3,
  parameter int unsigned AFULL_THRESH = 6
) (
  input  logic                  w_clk,
  input  logic                  w_rstn,
  input  logic                  w_inc,
  input  logic                  w_ovf_clr,
  input  logic [ADDR_WIDTH:0]   sync_rd_ptr,
  output logic                  w_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH:0]   gray_wr_ptr,
  output logic                  w_full,
  output logic                  w_afull,
  output logic [ADDR_WIDTH:0]   w_level,
  output logic                  w_ovf
);

  localparam int unsigned PW = ADDR_WIDTH + 1;

  logic [PW-1:0] w_ptr;
  logic [PW-1:0] w_ptr_nxt;
  logic [PW-1:0] rd_bin;

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray read pointer back to binary: bit i is the XOR of all bits at or above i
  always_comb begin
    rd_bin = '0;
    for (int i = 0; i < int'(PW); i++) begin
      rd_bin[i] = ^(sync_rd_ptr >> i);
    end
  end

  assign w_full    = (gray_wr_ptr == {~sync_rd_ptr[PW-1:PW-2], sync_rd_ptr[PW-3:0]});
  assign w_en      = w_inc & ~w_full;
  assign w_addr    = w_ptr[ADDR_WIDTH-1:0];
  assign w_ptr_nxt = w_ptr + PW'(1);
  assign w_level   = w_ptr - rd_bin;
  assign w_afull   = (w_level >= PW'(AFULL_THRESH));

  // Binary and Gray pointers advance together so the CDC source never lags the address
  always_ff @(posedge w_clk or negedge w_rstn) begin
    if (!w_rstn) begin
      w_ptr       <= '0;
      gray_wr_ptr <= '0;
    end else if (w_en) begin
      w_ptr       <= w_ptr_nxt;
      gray_wr_ptr <= bin2gray(w_ptr_nxt);
    end
  end

`ifdef FIFO_WR_OVF_EN
  // Sticky overflow: a rejected write wins over a same-cycle clear
  always_ff @(posedge w_clk or negedge w_rstn) begin
    if (!w_rstn) begin
      w_ovf <= 1'b0;
    end else if (w_inc & w_full) begin
      w_ovf <= 1'b1;
    end else if (w_ovf_clr) begin
      w_ovf <= 1'b0;
    end
  end
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = w_ovf_clr;
  assign w_ovf          = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed self-checking bench for fifo_wr_ctrl at ADDR_WIDTH 3 (main), 2 and 5 (parametric).
module tb_fifo_wr_ctrl;

`ifdef FIFO_WR_OVF_EN
  localparam logic OVF = 1'b1;
`else
  localparam logic OVF = 1'b0;
`endif

  localparam logic [3:0] GTAB [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                       4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  logic       w_clk;
  logic       w_rstn;
  logic       w_inc;
  logic       w_ovf_clr;
  logic [3:0] sync_rd_ptr;
  logic       w_en;
  logic [2:0] w_addr;
  logic [3:0] gray_wr_ptr;
  logic       w_full;
  logic       w_afull;
  logic [3:0] w_level;
  logic       w_ovf;

  logic       p2_inc, p2_clr, p2_en, p2_full, p2_afull, p2_ovf;
  logic [2:0] p2_sync, p2_gray, p2_level;
  logic [1:0] p2_addr;

  logic       p5_inc, p5_clr, p5_en, p5_full, p5_afull, p5_ovf;
  logic [5:0] p5_sync, p5_gray, p5_level;
  logic [4:0] p5_addr;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_wr_ctrl #(.ADDR_WIDTH(3), .AFULL_THRESH(6)) dut (
    .w_clk(w_clk), .w_rstn(w_rstn), .w_inc(w_inc), .w_ovf_clr(w_ovf_clr),
    .sync_rd_ptr(sync_rd_ptr), .w_en(w_en), .w_addr(w_addr), .gray_wr_ptr(gray_wr_ptr),
    .w_full(w_full), .w_afull(w_afull), .w_level(w_level), .w_ovf(w_ovf)
  );

  fifo_wr_ctrl #(.ADDR_WIDTH(2), .AFULL_THRESH(3)) dut2 (
    .w_clk(w_clk), .w_rstn(w_rstn), .w_inc(p2_inc), .w_ovf_clr(p2_clr),
    .sync_rd_ptr(p2_sync), .w_en(p2_en), .w_addr(p2_addr), .gray_wr_ptr(p2_gray),
    .w_full(p2_full), .w_afull(p2_afull), .w_level(p2_level), .w_ovf(p2_ovf)
  );

  fifo_wr_ctrl #(.ADDR_WIDTH(5), .AFULL_THRESH(31)) dut5 (
    .w_clk(w_clk), .w_rstn(w_rstn), .w_inc(p5_inc), .w_ovf_clr(p5_clr),
    .sync_rd_ptr(p5_sync), .w_en(p5_en), .w_addr(p5_addr), .gray_wr_ptr(p5_gray),
    .w_full(p5_full), .w_afull(p5_afull), .w_level(p5_level), .w_ovf(p5_ovf)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  // Return to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge w_clk);
    #1;
  endtask

  task automatic test_reset();
    w_rstn = 1'b0; w_inc = 1'b0; w_ovf_clr = 1'b0; sync_rd_ptr = '0;
    p2_inc = 1'b0; p2_clr = 1'b0; p2_sync = '0;
    p5_inc = 1'b0; p5_clr = 1'b0; p5_sync = '0;
    #12;
    n_checks++;
    if ({gray_wr_ptr, w_level, w_addr, w_full, w_afull, w_en, w_ovf} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_init: got gray=%h lvl=%0d addr=%0d full=%b afull=%b en=%b ovf=%b exp all 0",
               gray_wr_ptr, w_level, w_addr, w_full, w_afull, w_en, w_ovf);
    end
    tick();
    w_rstn = 1'b1;
    w_inc  = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (w_addr !== 3'd3 || gray_wr_ptr !== 4'h2) begin
      n_fail++;
      $display("FAIL burst_pre_reset: got addr=%0d gray=%h exp addr=3 gray=2", w_addr, gray_wr_ptr);
    end
    #2;
    w_rstn = 1'b0;
    w_inc  = 1'b0;
    #1;
    n_checks++;
    if ({gray_wr_ptr, w_level, w_addr, w_full, w_en, w_ovf} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_mid_burst: got gray=%h lvl=%0d addr=%0d full=%b en=%b ovf=%b exp all 0",
               gray_wr_ptr, w_level, w_addr, w_full, w_en, w_ovf);
    end
    tick();
    w_rstn = 1'b1;
    tick();
  endtask

  task automatic test_fill();
    sync_rd_ptr = '0;
    for (int i = 0; i < 8; i++) begin
      w_inc = 1'b1;
      #1;
      n_checks++;
      if (w_addr !== 3'(i) || w_en !== 1'b1 || w_full !== 1'b0 || w_level !== 4'(i) ||
          w_afull !== (i >= 6)) begin
        n_fail++;
        $display("FAIL fill_%0d: got addr=%0d en=%b full=%b lvl=%0d afull=%b exp addr=%0d en=1 full=0 lvl=%0d afull=%b",
                 i, w_addr, w_en, w_full, w_level, w_afull, i, i, (i >= 6));
      end
      tick();
    end
    w_inc = 1'b0;
    #1;
    n_checks++;
    if (w_full !== 1'b1 || gray_wr_ptr !== 4'b1100 || w_level !== 4'd8 || w_afull !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_full: got full=%b gray=%b lvl=%0d afull=%b exp full=1 gray=1100 lvl=8 afull=1",
               w_full, gray_wr_ptr, w_level, w_afull);
    end
    w_inc = 1'b1;
    #1;
    n_checks++;
    if (w_en !== 1'b0) begin
      n_fail++;
      $display("FAIL write_at_full_en: got en=%b exp 0", w_en);
    end
    tick();
    w_inc = 1'b0;
    #1;
    n_checks++;
    if (gray_wr_ptr !== 4'b1100 || w_addr !== 3'd0 || w_level !== 4'd8 || w_ovf !== OVF) begin
      n_fail++;
      $display("FAIL write_at_full_hold: got gray=%b addr=%0d lvl=%0d ovf=%b exp gray=1100 addr=0 lvl=8 ovf=%b",
               gray_wr_ptr, w_addr, w_level, w_ovf, OVF);
    end
  endtask

  task automatic test_drain_wrap();
    logic [3:0] prev;
    int         p;
    sync_rd_ptr = 4'b1100;
    #1;
    n_checks++;
    if (w_full !== 1'b0 || w_level !== 4'd0 || w_afull !== 1'b0) begin
      n_fail++;
      $display("FAIL drain: got full=%b lvl=%0d afull=%b exp full=0 lvl=0 afull=0", w_full, w_level, w_afull);
    end
    for (int k = 0; k < 16; k++) begin
      p = (8 + k) % 16;
      sync_rd_ptr = GTAB[p];
      w_inc = 1'b1;
      #1;
      n_checks++;
      if (w_en !== 1'b1 || w_addr !== 3'(p) || w_level !== 4'd0) begin
        n_fail++;
        $display("FAIL wrap_wr_%0d: got en=%b addr=%0d lvl=%0d exp en=1 addr=%0d lvl=0", k, w_en, w_addr, w_level, p % 8);
      end
      prev = gray_wr_ptr;
      tick();
      n_checks++;
      if (gray_wr_ptr !== GTAB[(p + 1) % 16] || $countones(prev ^ gray_wr_ptr) != 1) begin
        n_fail++;
        $display("FAIL wrap_gray_%0d: got %b -> %b exp %b (one-bit step)", k, prev, gray_wr_ptr, GTAB[(p + 1) % 16]);
      end
    end
    w_inc = 1'b0;
    sync_rd_ptr = 4'b0000;
    #1;
    n_checks++;
    if (w_full !== 1'b1 || w_level !== 4'd8) begin
      n_fail++;
      $display("FAIL refill_after_wrap: got full=%b lvl=%0d exp full=1 lvl=8", w_full, w_level);
    end
  endtask

  task automatic test_simultaneous();
    sync_rd_ptr = GTAB[1];
    w_inc = 1'b1;
    #1;
    n_checks++;
    if (w_en !== 1'b1 || w_full !== 1'b0 || w_level !== 4'd7) begin
      n_fail++;
      $display("FAIL simul_same_cycle: got en=%b full=%b lvl=%0d exp en=1 full=0 lvl=7", w_en, w_full, w_level);
    end
    tick();
    w_inc = 1'b0;
    #1;
    n_checks++;
    if (w_level !== 4'd8 || w_full !== 1'b1 || gray_wr_ptr !== GTAB[9]) begin
      n_fail++;
      $display("FAIL simul_next_cycle: got lvl=%0d full=%b gray=%b exp lvl=8 full=1 gray=1101", w_level, w_full, gray_wr_ptr);
    end
  endtask

  task automatic test_overflow();
    w_ovf_clr = 1'b1;
    tick();
    w_ovf_clr = 1'b0;
    n_checks++;
    if (w_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_initial_clear: got %b exp 0", w_ovf);
    end
    w_inc = 1'b1;
    tick();
    w_inc = 1'b0;
    n_checks++;
    if (w_ovf !== OVF || gray_wr_ptr !== GTAB[9]) begin
      n_fail++;
      $display("FAIL ovf_set: got ovf=%b gray=%b exp ovf=%b gray=1101", w_ovf, gray_wr_ptr, OVF);
    end
    repeat (2) tick();
    n_checks++;
    if (w_ovf !== OVF) begin
      n_fail++;
      $display("FAIL ovf_hold: got %b exp %b", w_ovf, OVF);
    end
    w_ovf_clr = 1'b1;
    tick();
    w_ovf_clr = 1'b0;
    n_checks++;
    if (w_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: got %b exp 0", w_ovf);
    end
    w_inc = 1'b1;
    w_ovf_clr = 1'b1;
    tick();
    w_inc = 1'b0;
    w_ovf_clr = 1'b0;
    n_checks++;
    if (w_ovf !== OVF) begin
      n_fail++;
      $display("FAIL ovf_set_beats_clr: got %b exp %b", w_ovf, OVF);
    end
  endtask

  task automatic test_parametric();
    logic [2:0] prev2;
    logic [5:0] prev5;
    logic [2:0] b2;
    // Depth 4: fill, reject, then stream 8 writes with the reader keeping up
    p2_sync = '0;
    for (int i = 0; i < 4; i++) begin
      p2_inc = 1'b1;
      #1;
      n_checks++;
      if (p2_full !== 1'b0 || p2_addr !== 2'(i) || p2_afull !== (i >= 3)) begin
        n_fail++;
        $display("FAIL aw2_fill_%0d: got full=%b addr=%0d afull=%b exp full=0 addr=%0d afull=%b",
                 i, p2_full, p2_addr, p2_afull, i, (i >= 3));
      end
      prev2 = p2_gray;
      tick();
      n_checks++;
      if ($countones(prev2 ^ p2_gray) != 1) begin
        n_fail++;
        $display("FAIL aw2_gray_%0d: got %b -> %b exp one-bit step", i, prev2, p2_gray);
      end
    end
    #1;
    n_checks++;
    if (p2_full !== 1'b1 || p2_level !== 3'd4 || p2_en !== 1'b0 || p2_gray !== 3'b110) begin
      n_fail++;
      $display("FAIL aw2_full: got full=%b lvl=%0d en=%b gray=%b exp full=1 lvl=4 en=0 gray=110",
               p2_full, p2_level, p2_en, p2_gray);
    end
    for (int k = 0; k < 8; k++) begin
      b2 = 3'(4 + k);
      p2_sync = b2 ^ (b2 >> 1);
      #1;
      prev2 = p2_gray;
      tick();
      n_checks++;
      if ($countones(prev2 ^ p2_gray) != 1 || p2_level !== 3'd1) begin
        n_fail++;
        $display("FAIL aw2_wrap_%0d: got %b -> %b lvl=%0d exp one-bit step lvl=1", k, prev2, p2_gray, p2_level);
      end
    end
    p2_inc = 1'b0;

    // Depth 32: afull at 31, full after exactly 32 writes
    p5_sync = '0;
    for (int i = 0; i < 32; i++) begin
      p5_inc = 1'b1;
      #1;
      n_checks++;
      if (p5_full !== 1'b0 || p5_level !== 6'(i) || p5_afull !== (i >= 31)) begin
        n_fail++;
        $display("FAIL aw5_fill_%0d: got full=%b lvl=%0d afull=%b exp full=0 lvl=%0d afull=%b",
                 i, p5_full, p5_level, p5_afull, i, (i >= 31));
      end
      prev5 = p5_gray;
      tick();
      n_checks++;
      if ($countones(prev5 ^ p5_gray) != 1) begin
        n_fail++;
        $display("FAIL aw5_gray_%0d: got %b -> %b exp one-bit step", i, prev5, p5_gray);
      end
    end
    #1;
    n_checks++;
    if (p5_full !== 1'b1 || p5_level !== 6'd32 || p5_en !== 1'b0 || p5_gray !== 6'b110000) begin
      n_fail++;
      $display("FAIL aw5_full: got full=%b lvl=%0d en=%b gray=%b exp full=1 lvl=32 en=0 gray=110000",
               p5_full, p5_level, p5_en, p5_gray);
    end
    p5_inc = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain_wrap();
    test_simultaneous();
    test_overflow();
    test_parametric();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
